fetch_mem_arbiter: RTL and testbench

FETCH_MEM_ARBITER -- requirements
Module: fetch_mem_arbiter

---
 rtl/fetch_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_fetch_mem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_mem_arbiter.sv
// Two-port round-robin arbiter that serialises 32-bit big-endian word transfers
// onto a byte-wide single-port instruction memory (fetch reads, loader read/write).
module fetch_mem_arbiter #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [31:0]       f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_done,
  output logic [31:0]       l_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r;
  logic [1:0]        beat_r;
  logic [ADDR_W-1:0] base_r;
  logic              we_r;
  logic              sel_loader_r;
  logic              last_loader_r;
  logic [31:0]       wdata_r;
  logic [23:0]       shift_r;
  logic [31:0]       f_rdata_r;
  logic [31:0]       l_rdata_r;
  logic              f_valid_r;
  logic              l_done_r;
  logic              grant_f_s;
  logic              grant_l_s;
  logic              in_xfer_s;

  // Big-endian byte lane for a given beat: beat 0 is the most significant byte.
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] beat);
    logic [7:0] b;
    case (beat)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Arbitration: only in IDLE and out of reset; a tie goes to the port not served last.
  always_comb begin
    grant_f_s = 1'b0;
    grant_l_s = 1'b0;
    if (rst_n && (state_r == IDLE)) begin
      if (f_req && (!l_req || last_loader_r)) begin
        grant_f_s = 1'b1;
      end else if (l_req) begin
        grant_l_s = 1'b1;
      end else begin
        grant_f_s = 1'b0;
      end
    end else begin
      grant_f_s = 1'b0;
    end
  end

  // Transfer sequencer: latches the request at grant, walks four beats, assembles read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      beat_r        <= 2'd0;
      base_r        <= {ADDR_W{1'b0}};
      we_r          <= 1'b0;
      sel_loader_r  <= 1'b0;
      last_loader_r <= 1'b1;
      wdata_r       <= 32'h0000_0000;
      shift_r       <= 24'h00_0000;
      f_rdata_r     <= 32'h0000_0000;
      l_rdata_r     <= 32'h0000_0000;
      f_valid_r     <= 1'b0;
      l_done_r      <= 1'b0;
    end else begin
      f_valid_r <= 1'b0;
      l_done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          beat_r <= 2'd0;
          if (grant_f_s || grant_l_s) begin
            state_r       <= XFER;
            base_r        <= grant_l_s ? {l_addr[ADDR_W-1:2], 2'b00} : {f_addr[ADDR_W-1:2], 2'b00};
            we_r          <= grant_l_s & l_we;
            wdata_r       <= l_wdata;
            sel_loader_r  <= grant_l_s;
            last_loader_r <= grant_l_s;
          end
        end
        XFER: begin
          // Memory returns data one cycle late, so beat k's byte lands while beat k+1 is driven.
          if (beat_r != 2'd0) begin
            shift_r <= {shift_r[15:0], mem_rdata};
          end
          beat_r <= beat_r + 2'd1;
          if (beat_r == 2'd3) begin
            state_r <= CAPT;
          end
        end
        CAPT: begin
          state_r   <= DONE;
          f_valid_r <= ~sel_loader_r;
          l_done_r  <= sel_loader_r;
          if (!we_r) begin
            if (sel_loader_r) begin
              l_rdata_r <= {shift_r, mem_rdata};
            end else begin
              f_rdata_r <= {shift_r, mem_rdata};
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_xfer_s = (state_r == XFER);
  assign f_gnt     = grant_f_s;
  assign l_gnt     = grant_l_s;
  assign f_valid   = f_valid_r;
  assign l_done    = l_done_r;
  assign f_rdata   = f_rdata_r;
  assign l_rdata   = l_rdata_r;
  assign busy      = (state_r != IDLE);
  assign mem_addr  = in_xfer_s ? (base_r + {{(ADDR_W-2){1'b0}}, beat_r}) : {ADDR_W{1'b0}};
  assign mem_we    = in_xfer_s & we_r;
  assign mem_wdata = (in_xfer_s & we_r) ? byte_of(wdata_r, beat_r) : 8'h00;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed self-checking bench for fetch_mem_arbiter with a byte-wide
// synchronous-read memory model.
module tb_fetch_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        f_req;
  logic [6:0]  f_addr;
  logic        f_gnt;
  logic        f_valid;
  logic [31:0] f_rdata;
  logic        l_req;
  logic        l_we;
  logic [6:0]  l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_done;
  logic [31:0] l_rdata;
  logic [6:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  logic [7:0]  mem [128];
  int          checks;
  int          errors;

  fetch_mem_arbiter #(.ADDR_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte memory: read data appears the cycle after the address, writes on the edge.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h04;
    mem[7'h7C] = 8'h11; mem[7'h7D] = 8'h22; mem[7'h7E] = 8'h33; mem[7'h7F] = 8'h44;
    rst_n = 1'b0; f_req = 1'b1; f_addr = 7'h00;
    l_req = 1'b0; l_we = 1'b0; l_addr = 7'h00; l_wdata = 32'h0;

    // Reset state: no grant even with a request pending
    #2;
    chk("rst_f_gnt", {31'b0, f_gnt}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {25'b0, mem_addr}, 32'd0);
    chk("rst_f_rdata", f_rdata, 32'd0);
    f_req = 1'b0;
    #10 rst_n = 1'b1;

    // Fetch of word 0
    tick();
    f_req = 1'b1; f_addr = 7'h00; #1;
    chk("f_gnt_T", {31'b0, f_gnt}, 32'd1);
    chk("l_gnt_T", {31'b0, l_gnt}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      f_req = 1'b0; f_addr = 7'h40;
      chk("f_addr_beat", {25'b0, mem_addr}, k);
      chk("f_busy", {31'b0, busy}, 32'd1);
      chk("f_we", {31'b0, mem_we}, 32'd0);
    end
    tick();
    chk("f_capt_addr", {25'b0, mem_addr}, 32'd0);
    chk("f_capt_valid", {31'b0, f_valid}, 32'd0);
    tick();
    chk("f_valid_T6", {31'b0, f_valid}, 32'd1);
    chk("f_rdata_T6", f_rdata, 32'h8C010004);
    chk("l_done_T6", {31'b0, l_done}, 32'd0);
    tick();
    chk("f_valid_T7", {31'b0, f_valid}, 32'd0);
    chk("f_rdata_hold", f_rdata, 32'h8C010004);
    chk("busy_T7", {31'b0, busy}, 32'd0);

    // Loader write to 0x11 -> 0x10..0x13
    l_req = 1'b1; l_we = 1'b1; l_addr = 7'h11; l_wdata = 32'hDEADBEEF; #1;
    chk("lw_gnt", {31'b0, l_gnt}, 32'd1);
    chk("lw_fgnt", {31'b0, f_gnt}, 32'd0);
    tick(); l_req = 1'b0; l_wdata = 32'h0; l_we = 1'b0;
    chk("lw_a0", {mem_we, 16'b0, mem_wdata, mem_addr}, {1'b1, 16'b0, 8'hDE, 7'h10});
    tick();
    chk("lw_a1", {mem_we, 16'b0, mem_wdata, mem_addr}, {1'b1, 16'b0, 8'hAD, 7'h11});
    tick();
    chk("lw_a2", {mem_we, 16'b0, mem_wdata, mem_addr}, {1'b1, 16'b0, 8'hBE, 7'h12});
    tick();
    chk("lw_a3", {mem_we, 16'b0, mem_wdata, mem_addr}, {1'b1, 16'b0, 8'hEF, 7'h13});
    tick();
    chk("lw_capt_we", {31'b0, mem_we}, 32'd0);
    tick();
    chk("lw_done", {31'b0, l_done}, 32'd1);
    chk("lw_fvalid", {31'b0, f_valid}, 32'd0);
    chk("lw_ldata_keep", l_rdata, 32'd0);
    tick();
    chk("lw_mem", {mem[7'h10], mem[7'h11], mem[7'h12], mem[7'h13]}, 32'hDEADBEEF);

    // Loader read-back of 0x10
    l_req = 1'b1; l_we = 1'b0; l_addr = 7'h12; #1;
    chk("lr_gnt", {31'b0, l_gnt}, 32'd1);
    tick(); l_req = 1'b0;
    repeat (5) tick();
    chk("lr_done", {31'b0, l_done}, 32'd1);
    chk("lr_rdata", l_rdata, 32'hDEADBEEF);
    chk("lr_frdata_keep", f_rdata, 32'h8C010004);
    tick();

    // Wrap: base 0x7E forced to 0x7C
    f_req = 1'b1; f_addr = 7'h7E; #1;
    chk("wr_gnt", {31'b0, f_gnt}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick(); f_req = 1'b0;
      chk("wr_addr", {25'b0, mem_addr}, 32'h7C + k);
    end
    repeat (2) tick();
    chk("wr_rdata", f_rdata, 32'h11223344);
    tick();

    // Both requests held from reset: fetch, loader, fetch every 7 cycles
    rst_n = 1'b0; #1;
    f_req = 1'b1; l_req = 1'b1; l_we = 1'b0; l_addr = 7'h00; f_addr = 7'h00;
    chk("rr_rst_gnt", {30'b0, f_gnt, l_gnt}, 32'd0);
    #2 rst_n = 1'b1; #1;
    chk("rr_g0", {30'b0, f_gnt, l_gnt}, 32'b10);
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 7) chk("rr_g7", {30'b0, f_gnt, l_gnt}, 32'b01);
      else if (c == 14) chk("rr_g14", {30'b0, f_gnt, l_gnt}, 32'b10);
      else chk("rr_gap", {30'b0, f_gnt, l_gnt}, 32'b00);
    end

    // Reset at T+2 of a write aborts it
    rst_n = 1'b0; f_req = 1'b0; l_req = 1'b0; #2 rst_n = 1'b1;
    tick();
    l_req = 1'b1; l_we = 1'b1; l_addr = 7'h20; l_wdata = 32'hA1B2C3D4; #1;
    chk("ab_gnt", {31'b0, l_gnt}, 32'd1);
    tick(); l_req = 1'b0;
    tick();
    chk("ab_we_T2", {mem_we, 24'b0, mem_addr}, {1'b1, 24'b0, 7'h21});
    rst_n = 1'b0; #1;
    chk("ab_async", {mem_we, busy, 23'b0, mem_addr}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("ab_no_done", {30'b0, l_done, busy}, 32'd0);
    end
    chk("ab_partial", {16'b0, mem[7'h20], mem[7'h21]}, 32'h0000A100);
    f_req = 1'b1; f_addr = 7'h00;
    #2 rst_n = 1'b1; #1;
    chk("ab_f_gnt", {31'b0, f_gnt}, 32'd1);
    tick(); f_req = 1'b0;
    chk("ab_f_busy", {31'b0, busy}, 32'd1);
    repeat (5) tick();
    chk("ab_f_valid", {31'b0, f_valid}, 32'd1);
    chk("ab_f_rdata", f_rdata, 32'h8C010004);
    chk("ab_l_done", {31'b0, l_done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
